wr_pll_reset_sequencer: RTL and testbench
=========================================

Name: wr_pll_reset_sequencer

Overview:
- Controls one Arria V PLL wrapper (refclk in; outclk, locked out) from the far side of its rst/locked interface.
- Drives the PLL reset pulse, waits for lock with a timeout, and requires lock to stay stable before releasing a downstream reset.
- Watches for loss of lock and re-runs the sequence automatically, up to a retry limit.
- Instantiated next to each PLL wrapper (DMTD, system, reference) in the platform layer.

Parameters:
g_RST_PULSE_CYCLES, 20, clk_sys_i cycles pll_rst_o is held high per attempt (>=1)
g_LOCK_TIMEOUT_CYCLES, 20000, cycles allowed from PLL reset release until synced lock (>=1)
g_LOCK_STABLE_CYCLES, 1024, consecutive synced-lock cycles required before release (>=1)
g_MAX_RETRIES, 7, failed attempts tolerated before S_FAIL; range 1..15

Ports:
clk_sys_i  in  1  free-running system clock, independent of the PLL output
rst_n_i  in  1  asynchronous active-low reset
pll_locked_i  in  1  PLL locked, asynchronous to clk_sys_i
restart_i  in  1  single-cycle request to restart the sequence from S_RESET
pll_rst_o  out  1  PLL reset, active-high, registered
rst_n_o  out  1  downstream reset for PLL-clocked logic, active-low, registered
ready_o  out  1  high only in S_RUN
fail_o  out  1  high only in S_FAIL
lock_lost_o  out  1  sticky flag: lock dropped while in S_RUN
retry_cnt_o  out  4  failed attempts since the last entry to S_RUN, saturating at 15

Behaviour:
- Reset is fixed: clk_sys_i is the only clock; rst_n_i is asynchronous, active-low, and applies to every flop.
- Values during rst_n_i=0:
  - state=S_RESET, timer=0
  - pll_rst_o=1, rst_n_o=0, ready_o=0, fail_o=0
  - lock_lost_o=0, retry_cnt_o=0
  - synchronizer flops=0
- Lock synchronizer: pll_locked_i passes through 2 flops to form lock_s. All decisions use lock_s, which lags the input by 2 cycles.
- Single timer, width clog2(max(all cycle parameters)+1). It is cleared on every state change.
- All outputs are registered and decoded from the next state.
- S_RESET:
  - pll_rst_o=1, rst_n_o=0.
  - After g_RST_PULSE_CYCLES cycles in this state, go to S_WAIT_LOCK.
- S_WAIT_LOCK:
  - pll_rst_o=0.
  - lock_s=1 goes to S_STABLE.
  - If the timer reaches g_LOCK_TIMEOUT_CYCLES with no lock, the attempt fails.
- S_STABLE:
  - lock_s=0 fails the attempt.
  - g_LOCK_STABLE_CYCLES consecutive cycles of lock_s=1 go to S_RUN. retry_cnt_o clears on entry to S_RUN.
- S_RUN:
  - rst_n_o=1, ready_o=1.
  - lock_s=0 sets lock_lost_o, drives rst_n_o=0 in the same registered update, and goes to S_RESET. This path does not increment retry_cnt_o.
- Failed attempt:
  - retry_cnt_o increments (saturating).
  - If the new count > g_MAX_RETRIES, go to S_FAIL; otherwise go to S_RESET.
- S_FAIL:
  - pll_rst_o=1, rst_n_o=0, fail_o=1.
  - Leaves only on restart_i or rst_n_i.
- restart_i:
  - From any state, goes to S_RESET and clears retry_cnt_o and lock_lost_o.
  - Takes priority over every other transition in the same cycle.
  - If asserted while in S_RESET, the pulse timer restarts.
- lock_lost_o stays set until restart_i or rst_n_i.
- A glitch of lock_s shorter than the stable window while in S_STABLE counts as a failed attempt; there is no partial credit.
- Timer arithmetic never wraps; comparisons are equality against the parameter value.

Decomposition:
- Shared package wr_pll_seq_pkg holds:
  - state enum: S_RESET, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAIL
  - the function f_log2_ceil
- One sub-module, gc_sync_ffs_2 (2-flop synchronizer, reset value 0). It is reusable for other async status inputs.
- Everything else stays in one FSM plus timer process.

Test Plan (params 4/50/8/2):
- Nominal lock: lock rises 10 cycles after pll_rst_o falls.
  - pll_rst_o high exactly 4 cycles after reset.
  - rst_n_o and ready_o rise 2+8 cycles after the lock edge.
  - retry_cnt_o=0.
- Never lock:
  - pll_rst_o pulses 3 times, each S_WAIT_LOCK lasts 50 cycles.
  - retry_cnt_o steps 1,2,3; fail_o=1 after the 3rd timeout.
  - pll_rst_o held at 1, rst_n_o=0.
- Glitchy lock: lock high 5 cycles, low 1, then steady.
  - One failed attempt, retry_cnt_o=1.
  - The second attempt reaches S_RUN and retry_cnt_o returns to 0.
- Lock loss in S_RUN: drop lock for 3 cycles.
  - lock_lost_o=1 and rst_n_o=0 within 3 cycles of the input edge.
  - A new 4-cycle pll_rst_o pulse follows; retry_cnt_o is unchanged.
- restart_i pulse while in S_FAIL, and again mid-S_STABLE:
  - Immediate S_RESET.
  - retry_cnt_o=0, lock_lost_o=0, fail_o=0.
  - Full 4-cycle pulse.
- rst_n_i asserted mid-S_STABLE: all outputs take their reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/wr_pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// wr_pll_seq_pkg
// Shared definitions for the PLL reset sequencer:
//   - t_seq_state : sequencer state encoding
//   - f_log2_ceil : ceil(log2(n)), used to size the sequencer timer
//   - f_max3      : largest of three cycle counts
// -----------------------------------------------------------------------------
package wr_pll_seq_pkg;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } t_seq_state;

    // Smallest r such that 2**r >= n.
    function automatic int f_log2_ceil(input int n);
        int r;
        r = 0;
        while ((32'sd1 << r) < n) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    function automatic int f_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gc_sync_ffs_2.sv
// -----------------------------------------------------------------------------
// gc_sync_ffs_2
// Two-flop synchronizer for a single asynchronous status bit.
// Ports:
//   clk_i    : destination clock
//   rst_n_i  : asynchronous active-low reset, both flops clear to 0
//   data_i   : asynchronous input
//   synced_o : data_i delayed by two clk_i edges, safe to use in clk_i domain
// -----------------------------------------------------------------------------
module gc_sync_ffs_2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic data_i,
    output logic synced_o
);

    logic meta_r;
    logic sync_r;

    // Metastability-filter chain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= data_i;
            sync_r <= meta_r;
        end
    end

    assign synced_o = sync_r;

endmodule

// File: rtl/wr_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// wr_pll_reset_sequencer
// Sequences one PLL: pulses its reset, waits for lock (with timeout), demands
// a window of uninterrupted lock, then releases the downstream reset. Loss of
// lock while running restarts the sequence; repeated failed attempts park the
// block in S_FAIL until restart_i or rst_n_i.
// Ports:
//   clk_sys_i    : free-running system clock (not the PLL output)
//   rst_n_i      : asynchronous active-low reset
//   pll_locked_i : PLL lock, asynchronous to clk_sys_i
//   restart_i    : single-cycle restart request, highest priority
//   pll_rst_o    : PLL reset, active-high
//   rst_n_o      : downstream reset, active-low (high only in S_RUN)
//   ready_o      : high only in S_RUN
//   fail_o       : high only in S_FAIL
//   lock_lost_o  : sticky, lock dropped while in S_RUN
//   retry_cnt_o  : failed attempts since last S_RUN entry, saturates at 15
// All outputs are registered and decoded from the next state.
// -----------------------------------------------------------------------------
module wr_pll_reset_sequencer
    import wr_pll_seq_pkg::*;
#(
    parameter int g_RST_PULSE_CYCLES    = 20,
    parameter int g_LOCK_TIMEOUT_CYCLES = 20000,
    parameter int g_LOCK_STABLE_CYCLES  = 1024,
    parameter int g_MAX_RETRIES         = 7
) (
    input  logic       clk_sys_i,
    input  logic       rst_n_i,
    input  logic       pll_locked_i,
    input  logic       restart_i,
    output logic       pll_rst_o,
    output logic       rst_n_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic       lock_lost_o,
    output logic [3:0] retry_cnt_o
);

    localparam int c_TIMER_MAX = f_max3(g_RST_PULSE_CYCLES, g_LOCK_TIMEOUT_CYCLES,
                                        g_LOCK_STABLE_CYCLES);
    localparam int c_TIMER_W   = f_log2_ceil(c_TIMER_MAX + 1);

    localparam logic [c_TIMER_W-1:0] c_TIMER_ZERO = {c_TIMER_W{1'b0}};
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE  = c_TIMER_W'(1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_SAT  = {c_TIMER_W{1'b1}};
    localparam logic [c_TIMER_W-1:0] c_PULSE      = c_TIMER_W'(g_RST_PULSE_CYCLES);
    localparam logic [c_TIMER_W-1:0] c_TIMEOUT    = c_TIMER_W'(g_LOCK_TIMEOUT_CYCLES);
    // The cycle that detects lock in S_WAIT_LOCK is the first of the stable
    // window, so S_STABLE itself only has to see the remaining cycles.
    localparam logic [c_TIMER_W-1:0] c_STABLE_REM = c_TIMER_W'(g_LOCK_STABLE_CYCLES - 1);
    localparam logic                 c_STABLE_ONE = (g_LOCK_STABLE_CYCLES == 1);
    localparam logic [4:0]           c_MAX_RETRIES = 5'(g_MAX_RETRIES);

    t_seq_state           state_r;
    t_seq_state           fsm_nxt_s;
    t_seq_state           state_nxt_s;
    logic [c_TIMER_W-1:0] timer_r;
    logic [c_TIMER_W-1:0] timer_inc_s;
    logic [c_TIMER_W-1:0] timer_nxt_s;
    logic [3:0]           retry_r;
    logic [3:0]           retry_nxt_s;
    logic [4:0]           retry_inc_s;
    logic                 lock_lost_r;
    logic                 lock_lost_nxt_s;
    logic                 attempt_fail_s;
    logic                 lock_drop_s;
    logic                 lock_s;
    logic                 pll_rst_r;
    logic                 rst_n_r;
    logic                 ready_r;
    logic                 fail_r;

    gc_sync_ffs_2 u_lock_sync (
        .clk_i    (clk_sys_i),
        .rst_n_i  (rst_n_i),
        .data_i   (pll_locked_i),
        .synced_o (lock_s)
    );

    // The timer never exceeds the largest parameter while it is compared,
    // so this increment cannot wrap where it matters.
    assign timer_inc_s = timer_r + c_TIMER_ONE;
    // One extra bit so the "too many retries" test still works at 15.
    assign retry_inc_s = {1'b0, retry_r} + 5'd1;

    // Per-state transition rules, before restart and failure resolution.
    always_comb begin
        fsm_nxt_s      = state_r;
        attempt_fail_s = 1'b0;
        lock_drop_s    = 1'b0;
        case (state_r)
            S_RESET: begin
                if (timer_inc_s == c_PULSE) begin
                    fsm_nxt_s = S_WAIT_LOCK;
                end else begin
                    fsm_nxt_s = S_RESET;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    fsm_nxt_s = c_STABLE_ONE ? S_RUN : S_STABLE;
                end else if (timer_inc_s == c_TIMEOUT) begin
                    attempt_fail_s = 1'b1;
                end else begin
                    fsm_nxt_s = S_WAIT_LOCK;
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    attempt_fail_s = 1'b1;
                end else if (timer_inc_s == c_STABLE_REM) begin
                    fsm_nxt_s = S_RUN;
                end else begin
                    fsm_nxt_s = S_STABLE;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    lock_drop_s = 1'b1;
                    fsm_nxt_s   = S_RESET;
                end else begin
                    fsm_nxt_s = S_RUN;
                end
            end
            S_FAIL: begin
                fsm_nxt_s = S_FAIL;
            end
            default: begin
                fsm_nxt_s = S_RESET;
            end
        endcase
    end

    // Final next state and counter/flag updates; restart_i overrides all.
    always_comb begin
        state_nxt_s     = fsm_nxt_s;
        retry_nxt_s     = retry_r;
        lock_lost_nxt_s = lock_lost_r;
        timer_nxt_s     = timer_r;

        if (restart_i) begin
            state_nxt_s = S_RESET;
        end else if (attempt_fail_s) begin
            state_nxt_s = (retry_inc_s > c_MAX_RETRIES) ? S_FAIL : S_RESET;
        end else begin
            state_nxt_s = fsm_nxt_s;
        end

        if (restart_i) begin
            retry_nxt_s = 4'd0;
        end else if (attempt_fail_s) begin
            retry_nxt_s = retry_inc_s[4] ? 4'd15 : retry_inc_s[3:0];
        end else if ((state_nxt_s == S_RUN) && (state_r != S_RUN)) begin
            retry_nxt_s = 4'd0;
        end else begin
            retry_nxt_s = retry_r;
        end

        if (restart_i) begin
            lock_lost_nxt_s = 1'b0;
        end else if (lock_drop_s) begin
            lock_lost_nxt_s = 1'b1;
        end else begin
            lock_lost_nxt_s = lock_lost_r;
        end

        // Restart in S_RESET keeps the state but must still restart the pulse.
        if (restart_i || (state_nxt_s != state_r)) begin
            timer_nxt_s = c_TIMER_ZERO;
        end else if (timer_r != c_TIMER_SAT) begin
            timer_nxt_s = timer_inc_s;
        end else begin
            timer_nxt_s = timer_r;
        end
    end

    // State, timer, counters and next-state-decoded output registers.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r     <= S_RESET;
            timer_r     <= c_TIMER_ZERO;
            retry_r     <= 4'd0;
            lock_lost_r <= 1'b0;
            pll_rst_r   <= 1'b1;
            rst_n_r     <= 1'b0;
            ready_r     <= 1'b0;
            fail_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            timer_r     <= timer_nxt_s;
            retry_r     <= retry_nxt_s;
            lock_lost_r <= lock_lost_nxt_s;
            pll_rst_r   <= (state_nxt_s == S_RESET) || (state_nxt_s == S_FAIL);
            rst_n_r     <= (state_nxt_s == S_RUN);
            ready_r     <= (state_nxt_s == S_RUN);
            fail_r      <= (state_nxt_s == S_FAIL);
        end
    end

    assign pll_rst_o   = pll_rst_r;
    assign rst_n_o     = rst_n_r;
    assign ready_o     = ready_r;
    assign fail_o      = fail_r;
    assign lock_lost_o = lock_lost_r;
    assign retry_cnt_o = retry_r;

endmodule

// File: tb/tb_wr_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wr_pll_reset_sequencer
// Self-checking bench for wr_pll_reset_sequencer with params 4/50/8/2.
// The reference model views the sequence as attempts: a reset pulse, then a
// listening phase that counts consecutive synced-lock cycles, then run/fail.
// -----------------------------------------------------------------------------
module tb_wr_pll_reset_sequencer;

    localparam int P_PULSE   = 4;
    localparam int P_TIMEOUT = 50;
    localparam int P_STABLE  = 8;
    localparam int P_MAXR    = 2;

    localparam int PH_PULSE  = 0;
    localparam int PH_LISTEN = 1;
    localparam int PH_RUN    = 2;
    localparam int PH_FAIL   = 3;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       lock    = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic       rst_n_out;
    logic       ready;
    logic       fail;
    logic       lost;
    logic [3:0] retry;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    int m_phase;
    int m_t;
    int m_good;
    int m_retry;
    bit m_lost;
    bit lq[$];

    always #5 clk = ~clk;

    wr_pll_reset_sequencer #(
        .g_RST_PULSE_CYCLES    (P_PULSE),
        .g_LOCK_TIMEOUT_CYCLES (P_TIMEOUT),
        .g_LOCK_STABLE_CYCLES  (P_STABLE),
        .g_MAX_RETRIES         (P_MAXR)
    ) dut (
        .clk_sys_i    (clk),
        .rst_n_i      (rst_n),
        .pll_locked_i (lock),
        .restart_i    (restart),
        .pll_rst_o    (pll_rst),
        .rst_n_o      (rst_n_out),
        .ready_o      (ready),
        .fail_o       (fail),
        .lock_lost_o  (lost),
        .retry_cnt_o  (retry)
    );

    function automatic void model_reset();
        m_phase = PH_PULSE;
        m_t     = 0;
        m_good  = 0;
        m_retry = 0;
        m_lost  = 1'b0;
        lq.delete();
        lq.push_back(1'b0);
        lq.push_back(1'b0);
    endfunction

    // Advance the model by one clock edge using the inputs present at it.
    function automatic void model_edge();
        bit ls;
        bit failed;
        int nr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ls = lq.pop_front();
        lq.push_back(lock);
        failed = 1'b0;
        if (restart) begin
            m_phase = PH_PULSE;
            m_t     = 0;
            m_retry = 0;
            m_lost  = 1'b0;
            return;
        end
        case (m_phase)
            PH_PULSE: begin
                m_t++;
                if (m_t == P_PULSE) begin
                    m_phase = PH_LISTEN;
                    m_t     = 0;
                    m_good  = 0;
                end
            end
            PH_LISTEN: begin
                m_t++;
                if (ls) begin
                    m_good++;
                    if (m_good == P_STABLE) begin
                        m_phase = PH_RUN;
                        m_retry = 0;
                    end
                end else if (m_good > 0 || m_t == P_TIMEOUT) begin
                    failed = 1'b1;
                end
            end
            PH_RUN: begin
                if (!ls) begin
                    m_lost  = 1'b1;
                    m_phase = PH_PULSE;
                    m_t     = 0;
                end
            end
            default: ;
        endcase
        if (failed) begin
            nr      = m_retry + 1;
            m_retry = (nr > 15) ? 15 : nr;
            m_phase = (nr > P_MAXR) ? PH_FAIL : PH_PULSE;
            m_t     = 0;
        end
    endfunction

    function automatic logic [8:0] exp_vec();
        return {(m_phase == PH_PULSE) || (m_phase == PH_FAIL), m_phase == PH_RUN,
                m_phase == PH_RUN, m_phase == PH_FAIL, m_lost, 4'(m_retry)};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {pll_rst, rst_n_out, ready, fail, lost, retry};
    endfunction

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        lock    = 1'b0;
        restart = 1'b0;
        model_reset();
        repeat (3) tick();
        n_checks++;
        if (dut_vec() !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0})
            $display("FAIL reset_values: got %b want %b", dut_vec(), {1'b1, 8'd0});
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        int hi;
        int k;
        hi = 0;
        while (pll_rst && hi < 20) begin
            hi++;
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL nominal_trace: got %b want %b", dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (hi !== P_PULSE) $display("FAIL nominal_pulse_len: got %0d want %0d", hi, P_PULSE);
        else n_pass++;
        repeat (10) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL nominal_trace: got %b want %b", dut_vec(), exp_vec());
            else n_pass++;
        end
        lock = 1'b1;
        k = 0;
        while (!ready && k < 40) begin
            k++;
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL nominal_trace: got %b want %b", dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (k !== 2 + P_STABLE) $display("FAIL nominal_ready_delay: got %0d want %0d", k, 2 + P_STABLE);
        else n_pass++;
        n_checks++;
        if ({rst_n_out, ready, retry} !== {1'b1, 1'b1, 4'd0})
            $display("FAIL nominal_run_outputs: got %b want %b", {rst_n_out, ready, retry}, 6'b110000);
        else n_pass++;
    endtask

    task automatic test_lock_loss();
        int k_seen;
        int hi;
        int k;
        k_seen = 0;
        lock = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL loss_trace: got %b want %b", dut_vec(), exp_vec());
            else n_pass++;
            if (k_seen == 0 && lost && !rst_n_out) k_seen = i;
        end
        lock = 1'b1;
        n_checks++;
        if (k_seen !== 3) $display("FAIL loss_reaction: got %0d want 3", k_seen);
        else n_pass++;
        hi = 0;
        while (pll_rst && hi < 20) begin
            hi++;
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL loss_trace: got %b want %b", dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (hi !== P_PULSE) $display("FAIL loss_pulse_len: got %0d want %0d", hi, P_PULSE);
        else n_pass++;
        n_checks++;
        if ({lost, retry} !== {1'b1, 4'd0}) $display("FAIL loss_flags: got %b want %b", {lost, retry}, 5'b10000);
        else n_pass++;
        k = 0;
        while (!ready && k < 100) begin
            k++;
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL loss_trace: got %b want %b", dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (ready !== 1'b1) $display("FAIL loss_relock: got %b want 1", ready);
        else n_pass++;
    endtask

    task automatic test_never_lock();
        int hi;
        int lo;
        lock    = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_checks++;
        if (dut_vec() !== exp_vec()) $display("FAIL never_trace: got %b want %b", dut_vec(), exp_vec());
        else n_pass++;
        for (int a = 1; a <= 3; a++) begin
            hi = 0;
            while (pll_rst && hi < 20) begin
                hi++;
                tick();
                n_checks++;
                if (dut_vec() !== exp_vec()) $display("FAIL never_trace: got %b want %b", dut_vec(), exp_vec());
                else n_pass++;
            end
            n_checks++;
            if (hi !== P_PULSE) $display("FAIL never_pulse_len: attempt %0d got %0d want %0d", a, hi, P_PULSE);
            else n_pass++;
            lo = 0;
            while (!pll_rst && lo < 100) begin
                lo++;
                tick();
                n_checks++;
                if (dut_vec() !== exp_vec()) $display("FAIL never_trace: got %b want %b", dut_vec(), exp_vec());
                else n_pass++;
            end
            n_checks++;
            if (lo !== P_TIMEOUT) $display("FAIL never_wait_len: attempt %0d got %0d want %0d", a, lo, P_TIMEOUT);
            else n_pass++;
            n_checks++;
            if (retry !== 4'(a)) $display("FAIL never_retry: got %0d want %0d", retry, a);
            else n_pass++;
        end
        n_checks++;
        if ({fail, pll_rst, rst_n_out, ready} !== 4'b1100)
            $display("FAIL never_fail_state: got %b want 1100", {fail, pll_rst, rst_n_out, ready});
        else n_pass++;
        repeat (10) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL never_hold: got %b want %b", dut_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_restart_fail();
        int hi;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_checks++;
        if ({fail, retry, lost, pll_rst} !== {1'b0, 4'd0, 1'b0, 1'b1})
            $display("FAIL restart_fail_clear: got %b want 0000001", {fail, retry, lost, pll_rst});
        else n_pass++;
        hi = 0;
        while (pll_rst && hi < 20) begin
            hi++;
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL restart_fail_trace: got %b want %b", dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (hi !== P_PULSE) $display("FAIL restart_fail_pulse: got %0d want %0d", hi, P_PULSE);
        else n_pass++;
    endtask

    task automatic test_restart_stable();
        int hi;
        int k;
        lock = 1'b1;
        k = 0;
        while (!ready && k < 100) begin
            k++;
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL restart_stable_trace: got %b want %b", dut_vec(), exp_vec());
            else n_pass++;
        end
        lock = 1'b0;
        repeat (3) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL restart_stable_trace: got %b want %b", dut_vec(), exp_vec());
            else n_pass++;
        end
        lock = 1'b1;
        n_checks++;
        if (lost !== 1'b1) $display("FAIL restart_stable_lost_set: got %b want 1", lost);
        else n_pass++;
        hi = 0;
        while (pll_rst && hi < 20) begin
            hi++;
            tick();
        end
        repeat (3) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL restart_stable_trace: got %b want %b", dut_vec(), exp_vec());
            else n_pass++;
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        n_checks++;
        if ({lost, retry, fail, pll_rst, rst_n_out} !== {1'b0, 4'd0, 1'b0, 1'b1, 1'b0})
            $display("FAIL restart_stable_clear: got %b want 00000010", {lost, retry, fail, pll_rst, rst_n_out});
        else n_pass++;
        hi = 0;
        while (pll_rst && hi < 20) begin
            hi++;
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL restart_stable_trace: got %b want %b", dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (hi !== P_PULSE) $display("FAIL restart_stable_pulse: got %0d want %0d", hi, P_PULSE);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int k;
        lock    = 1'b0;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        k = 0;
        while (pll_rst && k < 20) begin
            k++;
            tick();
        end
        repeat (3) tick();
        lock = 1'b1;
        repeat (5) tick();
        lock = 1'b0;
        tick();
        lock = 1'b1;
        k = 0;
        while (retry != 4'd1 && k < 30) begin
            k++;
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL glitch_trace: got %b want %b", dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if ({retry, ready} !== {4'd1, 1'b0}) $display("FAIL glitch_retry: got %b want 00010", {retry, ready});
        else n_pass++;
        k = 0;
        while (!ready && k < 100) begin
            k++;
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL glitch_trace: got %b want %b", dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if ({ready, retry} !== {1'b1, 4'd0}) $display("FAIL glitch_recover: got %b want 10000", {ready, retry});
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int k;
        lock    = 1'b1;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        k = 0;
        while (pll_rst && k < 20) begin
            k++;
            tick();
        end
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (dut_vec() !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0})
            $display("FAIL async_reset_values: got %b want %b", dut_vec(), {1'b1, 8'd0});
        else n_pass++;
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        k = 0;
        while (!ready && k < 100) begin
            k++;
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) $display("FAIL async_reset_trace: got %b want %b", dut_vec(), exp_vec());
            else n_pass++;
        end
        n_checks++;
        if (ready !== 1'b1) $display("FAIL async_reset_recover: got %b want 1", ready);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) lock = ~lock;
            restart = ($urandom_range(0, 199) == 0) || (fail && ($urandom_range(0, 9) == 0));
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec())
                $display("FAIL random_trace: cycle %0d got %b want %b", i, dut_vec(), exp_vec());
            else n_pass++;
        end
        restart = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_loss();
        test_never_lock();
        test_restart_fail();
        test_restart_stable();
        test_glitch();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
